// File: rtl/seg7_scan_pkg.sv
// Shared types and frame builder for the 7-segment scan sequencer.
// SEG_DIM_EN adds the dim-phase states used for PWM brightness.
package seg7_scan_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND,
      ST_HOLD,
      ST_BLANK
`ifdef SEG_DIM_EN
      ,
      ST_SEND_OFF,
      ST_HOLD_OFF
`endif
   } state_t;

   localparam logic [15:0] BLANK_FRAME = 16'hFFFF;
   localparam int SEL_LSB = 12;
   localparam int DOT_LSB = 8;

   // Digit i is selected by pulling sel_n[3-i] low; segments are inverted for the sink driver.
   function automatic logic [15:0] make_frame(input logic [1:0] idx, input logic [7:0] seg);
      logic [15:0] f;
      logic [3:0]  sel_n;
      sel_n = 4'b1111;
      sel_n[2'd3 - idx] = 1'b0;
      f = BLANK_FRAME;
      f[SEL_LSB +: 4] = sel_n;
      f[DOT_LSB +: 4] = 4'hF;
      f[7:0] = ~seg;
      return f;
   endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Frame handshake between the scan sequencer (master) and the shift-register driver (slave).
interface seg7_scan_ctrl_if;
   logic [15:0] frame_data;
   logic        frame_valid;
   logic        frame_ready;

   modport master (output frame_data, output frame_valid, input frame_ready);
   modport slave  (input frame_data, input frame_valid, output frame_ready);
endinterface

// File: rtl/seg7_slot_timer.sv
// Purpose: loadable down-counter timing a display slot; done while count is zero.
// Latency: value visible the cycle after load; decrements one per enabled cycle.
// Backpressure: none; the caller gates en.
module seg7_slot_timer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] value,
   input  logic             en,
   output logic             done
);

   logic [WIDTH-1:0] count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= value;
      end else if (en && count_q != '0) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign done = (count_q == '0);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Purpose: scans w_digit 7-seg digits, one 16-bit frame per slot to the shift driver (SEG_DIM_EN: PWM dimming).
// Latency: first frame valid 1 cycle after enable; next frame 1 cycle after the slot timer expires.
// Backpressure: frame held stable until ready; slot timer only starts after the transfer.
module seg7_scan_ctrl
   import seg7_scan_pkg::*;
#(
   parameter int clk_hz   = 500000,
   parameter int digit_hz = 2000,
   parameter int w_digit  = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable,
   input  logic [8*w_digit-1:0]   abcdefgh,
   seg7_scan_ctrl_if.master       frame,
   output logic                   sweep_done
`ifdef SEG_DIM_EN
   ,
   input  logic [2:0]             bright
`endif
);

   localparam int SLOT_CLKS = clk_hz / digit_hz;
   localparam int TW        = $clog2(SLOT_CLKS);
   localparam logic [1:0] LAST_IDX = 2'(w_digit - 1);

   if (SLOT_CLKS < 8) begin : g_bad_slot
      $error("seg7_scan_ctrl: clk_hz/digit_hz must be at least 8");
   end
   if (w_digit < 1 || w_digit > 4) begin : g_bad_digits
      $error("seg7_scan_ctrl: w_digit must be 1..4");
   end

   state_t               state_q, state_d;
   logic [1:0]           digit_q, digit_d;
   logic [8*w_digit-1:0] snap_q, snap_d;
   logic [15:0]          frame_q, frame_d;
   logic                 vld_q, vld_d;
   logic                 sd_q, sd_d;

   logic                 tmr_load, tmr_en, tmr_done;
   logic [TW-1:0]        tmr_val, on_val;

   logic                 last;
   logic [1:0]           adv_digit;
   logic [8*w_digit-1:0] adv_snap;
   logic [15:0]          adv_frame;

   function automatic logic [7:0] pick_seg(input logic [8*w_digit-1:0] s, input logic [1:0] idx);
      logic [7:0] r;
      r = s[7:0];
      for (int i = 1; i < w_digit; i++) begin
         if (idx == 2'(i)) r = s[8*i +: 8];
      end
      return r;
   endfunction

`ifdef SEG_DIM_EN
   localparam int SUB = SLOT_CLKS / 8;
   logic [2:0]    bright_q, bright_d;
   logic [TW-1:0] off_val;
   logic          off_zero;
   int            on_clks, off_clks;

   always_comb begin
      on_clks  = SUB * (int'(bright_q) + 1);
      off_clks = SLOT_CLKS - on_clks;
      on_val   = TW'(on_clks - 1);
      off_val  = TW'(off_clks - 1);
      off_zero = (off_clks == 0);
   end
`else
   assign on_val = TW'(SLOT_CLKS - 1);
`endif

   // Wrapping past the last digit is the only point where a fresh snapshot is taken.
   always_comb begin
      last      = (digit_q == LAST_IDX);
      adv_digit = last ? 2'd0 : digit_q + 2'd1;
      adv_snap  = last ? abcdefgh : snap_q;
      adv_frame = make_frame(adv_digit, pick_seg(adv_snap, adv_digit));
   end

   always_comb begin
      state_d  = state_q;
      digit_d  = digit_q;
      snap_d   = snap_q;
      frame_d  = frame_q;
      vld_d    = vld_q;
      sd_d     = 1'b0;
      tmr_load = 1'b0;
      tmr_val  = on_val;
      tmr_en   = 1'b0;
`ifdef SEG_DIM_EN
      bright_d = bright_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (enable) begin
               snap_d  = abcdefgh;
               digit_d = 2'd0;
               frame_d = make_frame(2'd0, abcdefgh[7:0]);
               vld_d   = 1'b1;
               state_d = ST_SEND;
`ifdef SEG_DIM_EN
               bright_d = bright;
`endif
            end
         end
         ST_SEND: begin
            if (frame.frame_ready) begin
               vld_d    = 1'b0;
               tmr_load = 1'b1;
               tmr_val  = on_val;
               state_d  = ST_HOLD;
            end
         end
         ST_HOLD: begin
            tmr_en = 1'b1;
            if (!enable) begin
               frame_d = BLANK_FRAME;
               vld_d   = 1'b1;
               state_d = ST_BLANK;
`ifdef SEG_DIM_EN
            end else if (tmr_done && !off_zero) begin
               frame_d = BLANK_FRAME;
               vld_d   = 1'b1;
               state_d = ST_SEND_OFF;
`endif
            end else if (tmr_done) begin
               digit_d = adv_digit;
               snap_d  = adv_snap;
               frame_d = adv_frame;
               vld_d   = 1'b1;
               sd_d    = last;
               state_d = ST_SEND;
`ifdef SEG_DIM_EN
               if (last) bright_d = bright;
`endif
            end
         end
         ST_BLANK: begin
            if (frame.frame_ready) begin
               vld_d   = 1'b0;
               state_d = ST_IDLE;
            end
         end
`ifdef SEG_DIM_EN
         ST_SEND_OFF: begin
            if (frame.frame_ready) begin
               vld_d    = 1'b0;
               tmr_load = 1'b1;
               tmr_val  = off_val;
               state_d  = ST_HOLD_OFF;
            end
         end
         ST_HOLD_OFF: begin
            tmr_en = 1'b1;
            if (!enable) begin
               frame_d = BLANK_FRAME;
               vld_d   = 1'b1;
               state_d = ST_BLANK;
            end else if (tmr_done) begin
               digit_d = adv_digit;
               snap_d  = adv_snap;
               frame_d = adv_frame;
               vld_d   = 1'b1;
               sd_d    = last;
               state_d = ST_SEND;
               if (last) bright_d = bright;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         digit_q  <= 2'd0;
         snap_q   <= '0;
         frame_q  <= BLANK_FRAME;
         vld_q    <= 1'b0;
         sd_q     <= 1'b0;
`ifdef SEG_DIM_EN
         bright_q <= 3'd0;
`endif
      end else begin
         state_q  <= state_d;
         digit_q  <= digit_d;
         snap_q   <= snap_d;
         frame_q  <= frame_d;
         vld_q    <= vld_d;
         sd_q     <= sd_d;
`ifdef SEG_DIM_EN
         bright_q <= bright_d;
`endif
      end
   end

   seg7_slot_timer #(.WIDTH(TW)) u_timer (
      .clk   (clk),
      .rst   (rst),
      .load  (tmr_load),
      .value (tmr_val),
      .en    (tmr_en),
      .done  (tmr_done)
   );

   assign frame.frame_data  = frame_q;
   assign frame.frame_valid = vld_q;
   assign sweep_done        = sd_q;

endmodule
